// File: rtl/core3_cpu_oci_dct_capture.sv
// DCT capture monitor: show-ahead FIFO of {count, word} with drop tracking and an
// end-of-test drain sequence that raises test_has_ended once the FIFO is empty.
module core3_cpu_oci_dct_capture #(
  parameter int unsigned DATA_W = 30,
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DROP_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] dct_buffer,
  input  logic [CNT_W-1:0]  dct_count,
  input  logic              dct_valid,
  input  logic              test_ending,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  rd_count,
  output logic [ADDR_W:0]   fill_level,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count,
  output logic              test_has_ended
);

  localparam int unsigned PtrW   = ADDR_W + 1;
  localparam int unsigned EntryW = CNT_W + DATA_W;
  localparam int unsigned Depth  = 2 ** ADDR_W;

  typedef enum logic [1:0] {StRun, StDrain, StEnded} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [EntryW-1:0]   mem_q [Depth];
  logic [EntryW-1:0]   mem_d [Depth];
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_count_q, drop_count_d;
  logic                test_has_ended_q, test_has_ended_d;

  logic empty, full, cand, push, pop, drop;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
            (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    pop   = !empty && rd_ready;
    cand  = dct_valid && (dct_count != '0) && (state_q == StRun);
    // A full FIFO still accepts when the head leaves in the same cycle.
    push  = cand && (!full || pop);
    drop  = cand && full && !pop;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_d        = mem_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (push) begin
      mem_d[wr_ptr_q[ADDR_W-1:0]] = {dct_count, dct_buffer};
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != '1) begin
        drop_count_d = drop_count_q + DROP_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (test_ending) state_d = StDrain;
      StDrain: if (empty) state_d = StEnded;
      StEnded: state_d = StEnded;
      default: state_d = StRun;
    endcase
    test_has_ended_d = (state_d == StEnded);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StRun;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      overflow_q       <= 1'b0;
      drop_count_q     <= '0;
      test_has_ended_q <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      overflow_q       <= overflow_d;
      drop_count_q     <= drop_count_d;
      test_has_ended_q <= test_has_ended_d;
      mem_q            <= mem_d;
    end
  end

  assign rd_valid       = !empty;
  assign {rd_count, rd_data} = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign fill_level     = wr_ptr_q - rd_ptr_q;
  assign overflow       = overflow_q;
  assign drop_count     = drop_count_q;
  assign test_has_ended = test_has_ended_q;

endmodule

// File: tb/tb_core3_cpu_oci_dct_capture.sv
// Randomised bench for the DCT capture monitor: a reference model tracks occupancy,
// drops and phase; a scoreboard queue holds expected FIFO entries for the monitor.
module tb_core3_cpu_oci_dct_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [29:0] d_data;
  logic [3:0]  d_count;
  logic        d_valid, d_end, d_ready;
  logic        rd_valid;
  logic [29:0] rd_data;
  logic [3:0]  rd_count;
  logic [4:0]  fill_level;
  logic        overflow;
  logic [15:0] drop_count;
  logic        test_has_ended;

  core3_cpu_oci_dct_capture dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .dct_buffer    (d_data),
    .dct_count     (d_count),
    .dct_valid     (d_valid),
    .test_ending   (d_end),
    .rd_ready      (d_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_count      (rd_count),
    .fill_level    (fill_level),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .test_has_ended(test_has_ended)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = capturing, 1 = draining, 2 = finished.
  logic [33:0] exp_q[$];
  int          m_level, m_drops, m_phase;
  logic        m_ovf;
  int          n_vec, n_err, n_chk;
  bit          checking;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_level = 0;
    m_drops = 0;
    m_ovf   = 1'b0;
    m_phase = 0;
  endtask

  // Applies the spec rules for one clock edge using the inputs held across it.
  task automatic model_edge();
    bit pop, cand, push, drop;
    int old_level;
    old_level = m_level;
    pop  = (m_level > 0) && d_ready;
    cand = d_valid && (d_count != 0) && (m_phase == 0);
    push = cand && ((m_level < 16) || pop);
    drop = cand && !push;
    if (push) exp_q.push_back({d_count, d_data});
    m_level = m_level + int'(push) - int'(pop);
    if (drop) begin
      m_ovf = 1'b1;
      if (m_drops < 65535) m_drops++;
    end
    if (m_phase == 0 && d_end) m_phase = 1;
    else if (m_phase == 1 && old_level == 0) m_phase = 2;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge();
    n_vec++;
    #1;
  endtask

  task automatic idle_inputs();
    d_valid = 1'b0; d_end = 1'b0; d_ready = 1'b0; d_count = '0; d_data = '0;
  endtask

  task automatic rand_word(input bit allow_zero);
    d_data  = 30'($urandom());
    d_count = allow_zero ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 15));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rd_valid"}, 64'(rd_valid), 0);
    check({tag, " rd_data"}, 64'(rd_data), 0);
    check({tag, " rd_count"}, 64'(rd_count), 0);
    check({tag, " fill_level"}, 64'(fill_level), 0);
    check({tag, " overflow"}, 64'(overflow), 0);
    check({tag, " drop_count"}, 64'(drop_count), 0);
    check({tag, " test_has_ended"}, 64'(test_has_ended), 0);
  endtask

  task automatic do_reset(input string tag);
    checking = 1'b0;
    reset_n  = 1'b0;
    #1;
    check_all_zero(tag);
    model_reset();
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset_n  = 1'b1;
    checking = 1'b1;
  endtask

  task automatic drain_to_empty(input string tag);
    d_valid = 1'b0;
    d_ready = 1'b1;
    for (int i = 0; i < 40 && m_level != 0; i++) step();
    d_ready = 1'b0;
    check({tag, " drained fill_level"}, 64'(fill_level), 0);
  endtask

  // Monitor: compares status each cycle and the head entry against the scoreboard.
  always @(negedge clk) begin
    if (checking && reset_n) begin
      check("rd_valid", 64'(rd_valid), 64'(m_level != 0));
      check("fill_level", 64'(fill_level), 64'(m_level));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("drop_count", 64'(drop_count), 64'(m_drops));
      check("test_has_ended", 64'(test_has_ended), 64'(m_phase == 2));
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check("head present in scoreboard", 64'(rd_valid), 0);
        end else begin
          check("head entry", 64'({rd_count, rd_data}), 64'(exp_q[0]));
          if (d_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int base_drops;
    n_vec = 0; n_err = 0; n_chk = 0;
    checking = 1'b0;
    model_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n  = 1'b1;
    checking = 1'b1;
    repeat (3) step();
    check_all_zero("idle");

    // Basic flow
    d_valid = 1'b1; d_data = 30'h0000001; d_count = 4'd1;
    step();
    check("rd_valid after first push", 64'(rd_valid), 1);
    d_data = 30'h2AAAAAAA; d_count = 4'd4;
    step();
    d_data = 30'h3FFFFFFF; d_count = 4'd15;
    step();
    d_valid = 1'b0;
    check("basic fill_level", 64'(fill_level), 3);
    check("basic head", 64'({rd_count, rd_data}), 64'({4'd1, 30'h0000001}));
    d_ready = 1'b1;
    repeat (3) step();
    check("basic drained", 64'(fill_level), 0);
    d_ready = 1'b0;

    // Full and overflow
    d_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      rand_word(1'b0);
      step();
    end
    check("full fill_level", 64'(fill_level), 16);
    check("full overflow", 64'(overflow), 1);
    check("full drop_count", 64'(drop_count), 2);
    rand_word(1'b0);
    d_ready = 1'b1;
    step();
    d_valid = 1'b0; d_ready = 1'b0;
    check("full push+pop fill", 64'(fill_level), 16);
    check("full push+pop drops", 64'(drop_count), 2);
    drain_to_empty("full");

    // Zero-count filter
    do_reset("reset2");
    d_valid = 1'b1; d_count = 4'd0; d_data = 30'h1234567;
    repeat (5) step();
    d_valid = 1'b0;
    check("zero fill_level", 64'(fill_level), 0);
    check("zero drop_count", 64'(drop_count), 0);
    check("zero overflow", 64'(overflow), 0);

    // Random traffic while capturing
    for (int i = 0; i < 400; i++) begin
      d_valid = 1'($urandom_range(0, 1));
      d_ready = ($urandom_range(0, 3) == 0);
      rand_word(1'b1);
      step();
    end
    drain_to_empty("random");

    // Drain sequence
    d_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_word(1'b0);
      step();
    end
    base_drops = m_drops;
    rand_word(1'b0);
    d_end = 1'b1;
    step();
    d_end = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_word(1'b0);
      step();
    end
    d_valid = 1'b0;
    check("drain fill_level", 64'(fill_level), 5);
    check("drain drop_count", 64'(drop_count), 64'(base_drops));
    d_ready = 1'b1;
    for (int i = 0; i < 40 && !test_has_ended; i++) step();
    check("drain test_has_ended", 64'(test_has_ended), 1);
    for (int i = 0; i < 10; i++) begin
      d_end = 1'($urandom_range(0, 1));
      d_valid = 1'b1;
      rand_word(1'b0);
      step();
    end
    idle_inputs();
    step();
    check("ended held", 64'(test_has_ended), 1);
    check("ended fill_level", 64'(fill_level), 0);

    // Saturation, then reset while draining
    do_reset("reset3");
    d_valid = 1'b1;
    for (int i = 0; i < 16 + 65539; i++) begin
      rand_word(1'b0);
      step();
    end
    check("sat drop_count", 64'(drop_count), 64'hFFFF);
    check("sat overflow", 64'(overflow), 1);
    d_end = 1'b1;
    step();
    idle_inputs();
    repeat (2) step();
    check("sat in drain fill", 64'(fill_level), 16);
    check("sat not ended", 64'(test_has_ended), 0);
    do_reset("mid-drain reset");
    d_valid = 1'b1; d_data = 30'h0ABCDEF; d_count = 4'd7;
    step();
    d_valid = 1'b0;
    check("post-reset capture valid", 64'(rd_valid), 1);
    check("post-reset capture head", 64'({rd_count, rd_data}), 64'({4'd7, 30'h0ABCDEF}));
    drain_to_empty("final");

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
